// File: rtl/btn_evt_pkg.sv
// Shared definitions for the button event controller: event field widths
// and press/release encoding.
package btn_evt_pkg;

  localparam logic EVT_PRESS   = 1'b1;
  localparam logic EVT_RELEASE = 1'b0;

  function automatic int id_width(input int n_btn);
    return (n_btn > 1) ? $clog2(n_btn) : 1;
  endfunction

  function automatic int evt_width(input int n_btn);
    return id_width(n_btn) + 1;
  endfunction

endpackage

// File: rtl/evt_fifo.sv
// Show-ahead synchronous FIFO; head entry is visible on dout whenever empty is low.
// Pointers carry one extra wrap bit so full/empty come from the MSB comparison.
module evt_fifo #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= din;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/btn_event_ctrl.sv
// Button debouncer with press/release event generation, round-robin arbitration
// of pending channel events and a show-ahead event FIFO toward the consumer.
module btn_event_ctrl
  import btn_evt_pkg::*;
#(
  parameter int  N_BTN        = 4,
  parameter int  TICK_DIV     = 1000,
  parameter int  STABLE_TICKS = 8,
  parameter int  FIFO_DEPTH   = 4,
  localparam int ID_W         = id_width(N_BTN)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn_in,
  output logic [N_BTN-1:0] level_out,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [ID_W-1:0]  evt_id,
  output logic             evt_press,
  output logic             evt_drop
);

  localparam int EVT_W = evt_width(N_BTN);
  localparam int DIV_W = $clog2(TICK_DIV);
  localparam int CNT_W = $clog2(STABLE_TICKS) + 1;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic            press;
  } evt_t;

  logic [N_BTN-1:0] sync_q;
  logic [N_BTN-1:0] s;
  logic [DIV_W-1:0] div;
  logic             tick;
  logic [CNT_W-1:0] cnt [N_BTN];
  logic [N_BTN-1:0] flip;
  logic [N_BTN-1:0] pend;
  logic [N_BTN-1:0] pol;
  logic [ID_W-1:0]  rr_ptr;
  logic [N_BTN-1:0] gnt;
  logic [ID_W-1:0]  gnt_id;
  logic             gnt_any;
  logic             fifo_full;
  logic             fifo_empty;
  evt_t             push_evt;
  evt_t             head_evt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      s      <= '0;
    end else begin
      sync_q <= btn_in;
      s      <= sync_q;
    end
  end

  assign tick = (div == DIV_W'(TICK_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) div <= '0;
    else        div <= tick ? '0 : div + 1'b1;
  end

  // A channel flips on the tick that completes its run of disagreeing samples.
  always_comb begin
    flip = '0;
    for (int i = 0; i < N_BTN; i++)
      flip[i] = tick && (s[i] != level_out[i]) && (cnt[i] == CNT_W'(STABLE_TICKS - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_BTN; i++) cnt[i] <= '0;
      level_out <= '0;
    end else begin
      for (int i = 0; i < N_BTN; i++) begin
        if (tick) begin
          if (s[i] == level_out[i] || flip[i]) cnt[i] <= '0;
          else                                 cnt[i] <= cnt[i] + 1'b1;
        end
      end
      level_out <= level_out ^ flip;
    end
  end

  always_comb begin
    int idx;
    gnt     = '0;
    gnt_id  = '0;
    gnt_any = 1'b0;
    idx     = 0;
    if (!fifo_full) begin
      for (int k = 1; k <= N_BTN; k++) begin
        idx = (int'(rr_ptr) + k) % N_BTN;
        if (!gnt_any && pend[idx]) begin
          gnt_any  = 1'b1;
          gnt[idx] = 1'b1;
          gnt_id   = ID_W'(idx);
        end
      end
    end
  end

  // A flip in the grant cycle re-arms pend; the FIFO still takes the old pol.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend     <= '0;
      pol      <= '0;
      rr_ptr   <= ID_W'(N_BTN - 1);
      evt_drop <= 1'b0;
    end else begin
      for (int i = 0; i < N_BTN; i++) begin
        if (flip[i]) begin
          pend[i] <= 1'b1;
          pol[i]  <= ~level_out[i];
        end else if (gnt[i]) begin
          pend[i] <= 1'b0;
        end
      end
      if (gnt_any) rr_ptr <= gnt_id;
      evt_drop <= |(flip & pend & ~gnt);
    end
  end

  assign push_evt.id    = gnt_id;
  assign push_evt.press = |(pol & gnt);

  evt_fifo #(
    .WIDTH (EVT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (gnt_any),
    .din   (push_evt),
    .pop   (evt_ready),
    .dout  (head_evt),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign evt_valid = ~fifo_empty;
  assign evt_id    = head_evt.id;
  assign evt_press = head_evt.press;

endmodule

// File: tb/tb_btn_event_ctrl.sv
// Directed bench for btn_event_ctrl with N_BTN=4, TICK_DIV=4, STABLE_TICKS=3, FIFO_DEPTH=4.
module tb_btn_event_ctrl;
  import btn_evt_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] btn_in = 4'h0;
  logic [3:0] level_out;
  logic       evt_valid;
  logic       evt_ready = 1'b0;
  logic [1:0] evt_id;
  logic       evt_press;
  logic       evt_drop;

  int n_checks = 0;
  int n_fail   = 0;
  int drop_cnt = 0;

  btn_event_ctrl #(
    .N_BTN        (4),
    .TICK_DIV     (4),
    .STABLE_TICKS (3),
    .FIFO_DEPTH   (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_in    (btn_in),
    .level_out (level_out),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_id    (evt_id),
    .evt_press (evt_press),
    .evt_drop  (evt_drop)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (rst_n && evt_drop === 1'b1) drop_cnt++;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic get_evt(input string tag, input int exp_id, input logic exp_press);
    int n = 0;
    while (evt_valid !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " valid"}, 32'(evt_valid), 32'd1);
    chk({tag, " id"}, 32'(evt_id), 32'(exp_id));
    chk({tag, " press"}, 32'(evt_press), 32'(exp_press));
    evt_ready = 1'b1;
    @(negedge clk);
    evt_ready = 1'b0;
  endtask

  initial begin
    int vcnt;
    int lat;
    int d0;

    // reset with all buttons held
    btn_in = 4'hF;
    rst_n  = 1'b0;
    cycles(3);
    chk("rst level", 32'(level_out), 32'h0);
    chk("rst valid", 32'(evt_valid), 32'h0);
    chk("rst id", 32'(evt_id), 32'h0);
    chk("rst press", 32'(evt_press), 32'h0);
    chk("rst drop", 32'(evt_drop), 32'h0);
    rst_n = 1'b1;
    cycles(11);
    chk("level before 3rd tick", 32'(level_out), 32'h0);
    chk("valid before flip", 32'(evt_valid), 32'h0);
    cycles(1);
    chk("level after 3rd tick", 32'(level_out), 32'hF);
    chk("valid at flip", 32'(evt_valid), 32'h0);
    cycles(1);
    chk("valid after grant", 32'(evt_valid), 32'h1);
    get_evt("init ev0", 0, EVT_PRESS);
    get_evt("init ev1", 1, EVT_PRESS);
    get_evt("init ev2", 2, EVT_PRESS);
    get_evt("init ev3", 3, EVT_PRESS);

    // release everything
    btn_in = 4'h0;
    get_evt("rel ev0", 0, EVT_RELEASE);
    get_evt("rel ev1", 1, EVT_RELEASE);
    get_evt("rel ev2", 2, EVT_RELEASE);
    get_evt("rel ev3", 3, EVT_RELEASE);
    chk("level all released", 32'(level_out), 32'h0);

    // bounce on ch2 must be rejected
    vcnt = 0;
    for (int p = 0; p < 10; p++) begin
      btn_in[2] = (p % 2 == 0);
      repeat (6) begin
        @(negedge clk);
        if (evt_valid === 1'b1) vcnt++;
      end
    end
    chk("bounce level", 32'(level_out), 32'h0);
    chk("bounce no event", 32'(vcnt), 32'h0);
    btn_in[2] = 1'b1;
    lat = 0;
    while (evt_valid !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    chk("stable latency in 12..15", 32'(lat >= 12 && lat <= 15), 32'h1);
    get_evt("stable ch2", 2, EVT_PRESS);
    chk("stable level", 32'(level_out), 32'h4);

    // round-robin from rr_ptr=2: ch3 first, then ch0/ch1 on the same tick
    btn_in[3] = 1'b1;
    cycles(4);
    btn_in[1:0] = 2'b11;
    get_evt("rr first", 3, EVT_PRESS);
    get_evt("rr second", 0, EVT_PRESS);
    get_evt("rr third", 1, EVT_PRESS);
    chk("rr level", 32'(level_out), 32'hF);

    // backpressure: four queued, fifth held pending
    d0 = drop_cnt;
    btn_in[0] = 1'b0; cycles(20);
    btn_in[1] = 1'b0; cycles(20);
    btn_in[2] = 1'b0; cycles(20);
    btn_in[3] = 1'b0; cycles(20);
    btn_in[0] = 1'b1; cycles(20);
    chk("bp valid held", 32'(evt_valid), 32'h1);
    chk("bp head id", 32'(evt_id), 32'h0);
    chk("bp head press", 32'(evt_press), 32'h0);
    chk("bp level", 32'(level_out), 32'h1);
    chk("bp no drop", 32'(drop_cnt - d0), 32'h0);
    get_evt("bp ev0", 0, EVT_RELEASE);
    get_evt("bp ev1", 1, EVT_RELEASE);
    get_evt("bp ev2", 2, EVT_RELEASE);
    get_evt("bp ev3", 3, EVT_RELEASE);
    get_evt("bp ev4", 0, EVT_PRESS);
    cycles(2);
    chk("bp drained", 32'(evt_valid), 32'h0);

    // overwrite: FIFO full, ch1 presses then releases while pending
    btn_in[2] = 1'b1; cycles(20);
    btn_in[3] = 1'b1; cycles(20);
    btn_in[2] = 1'b0; cycles(20);
    btn_in[3] = 1'b0; cycles(20);
    d0 = drop_cnt;
    btn_in[1] = 1'b1; cycles(20);
    chk("ow level press", 32'(level_out), 32'h3);
    chk("ow no drop yet", 32'(drop_cnt - d0), 32'h0);
    btn_in[1] = 1'b0; cycles(20);
    chk("ow single drop", 32'(drop_cnt - d0), 32'h1);
    chk("ow level release", 32'(level_out), 32'h1);
    get_evt("ow ev0", 2, EVT_PRESS);
    get_evt("ow ev1", 3, EVT_PRESS);
    get_evt("ow ev2", 2, EVT_RELEASE);
    get_evt("ow ev3", 3, EVT_RELEASE);
    get_evt("ow ch1", 1, EVT_RELEASE);
    cycles(3);
    chk("ow drained", 32'(evt_valid), 32'h0);

    // reset with three events queued
    btn_in[0] = 1'b0; cycles(20);
    btn_in[1] = 1'b1; cycles(20);
    btn_in[2] = 1'b1; cycles(20);
    chk("mid queued valid", 32'(evt_valid), 32'h1);
    chk("mid queued head", 32'(evt_id), 32'h0);
    rst_n = 1'b0;
    #1;
    chk("mid rst valid", 32'(evt_valid), 32'h0);
    chk("mid rst level", 32'(level_out), 32'h0);
    chk("mid rst id", 32'(evt_id), 32'h0);
    btn_in = 4'h0;
    @(negedge clk);
    rst_n = 1'b1;
    vcnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (evt_valid === 1'b1) vcnt++;
    end
    chk("post rst no events", 32'(vcnt), 32'h0);
    chk("post rst level", 32'(level_out), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
